mem_arbiter: RTL and testbench

- Shares the single `memory_com` UART memory channel between two CPU requesters: instruction fetch (IF) and load/store data (D).
- Grants one requester at a time and holds `memory_com`'s enables steady until `mem_done`.
- Returns read data and a one-cycle done pulse to the granted requester.
- Includes a stall watchdog and a compile-time round-robin option.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory_com arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic       PORT_IF       = 1'b0;
    localparam logic       PORT_D        = 1'b1;
    localparam logic [2:0] SIZE_WORD     = 3'b010;
    localparam logic [1:0] MEMWRITE_NONE = 2'b00;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between IF and D requesters.
// MEM_ARB_RR_EN selects round-robin; otherwise D has fixed priority over IF.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req_i,
    input  logic d_req_i,
    input  logic last_i,
    output logic any_o,
    output logic win_o
);

    assign any_o = if_req_i | d_req_i;

`ifdef MEM_ARB_RR_EN
    // On a tie the port that did not win last time goes next.
    assign win_o = (if_req_i && d_req_i) ? ~last_i : d_req_i;
`else
    logic unused_last;
    assign unused_last = last_i;
    assign win_o       = d_req_i ? PORT_D : PORT_IF;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory_com channel between instruction fetch and data ports.
// Define MEM_ARB_RR_EN for round-robin selection instead of fixed D-over-IF priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 2_000_000,
    parameter int TW      = 22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_sizeload,
    input  logic [1:0]  d_memwrite,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        write_enable,
    output logic        read_enable,
    output logic [31:0] address,
    output logic [31:0] writeData,
    output logic [2:0]  SizeLoad,
    output logic [1:0]  MemWrite,
    input  logic        mem_done,
    input  logic [31:0] readData,
    output logic        grant_d,
    output logic        timeout_err
);

    state_e        state_q;
    logic [TW-1:0] cnt_q;
    logic [31:0]   if_rdata_q, d_rdata_q, addr_q, wdata_q;
    logic          if_done_q, d_done_q, we_q, re_q, grant_d_q, err_q;
    logic [2:0]    size_q;
    logic [1:0]    mw_q;
    logic          last_q;
    logic          any, win;

    mem_arb_pick u_pick (
        .if_req_i (if_req),
        .d_req_i  (d_read | d_write),
        .last_i   (last_q),
        .any_o    (any),
        .win_o    (win)
    );

`ifndef MEM_ARB_RR_EN
    assign last_q = PORT_IF;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            mw_q       <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            grant_d_q  <= 1'b0;
            err_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q     <= PORT_IF;
`endif
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any) begin
                        grant_d_q <= win;
                        if (win == PORT_D) begin
                            // A store takes precedence over a simultaneous load.
                            we_q    <= d_write;
                            re_q    <= ~d_write & d_read;
                            addr_q  <= d_addr;
                            wdata_q <= d_wdata;
                            size_q  <= d_sizeload;
                            mw_q    <= d_memwrite;
                        end else begin
                            we_q    <= 1'b0;
                            re_q    <= 1'b1;
                            addr_q  <= if_addr;
                            wdata_q <= '0;
                            size_q  <= SIZE_WORD;
                            mw_q    <= MEMWRITE_NONE;
                        end
                        cnt_q   <= '0;
                        state_q <= ST_BUSY;
`ifdef MEM_ARB_RR_EN
                        last_q  <= win;
`endif
                    end
                end
                ST_BUSY: begin
                    // Saturating watchdog; the transaction itself keeps waiting.
                    if (TIMEOUT != 0 && cnt_q != TW'(TIMEOUT)) begin
                        cnt_q <= cnt_q + TW'(1);
                        if (cnt_q + TW'(1) == TW'(TIMEOUT))
                            err_q <= 1'b1;
                    end
                    if (mem_done) begin
                        we_q      <= 1'b0;
                        re_q      <= 1'b0;
                        grant_d_q <= 1'b0;
                        if (re_q) begin
                            if (grant_d_q) d_rdata_q  <= readData;
                            else           if_rdata_q <= readData;
                        end
                        if (grant_d_q) d_done_q  <= 1'b1;
                        else           if_done_q <= 1'b1;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign if_rdata     = if_rdata_q;
    assign if_done      = if_done_q;
    assign d_rdata      = d_rdata_q;
    assign d_done       = d_done_q;
    assign write_enable = we_q;
    assign read_enable  = re_q;
    assign address      = addr_q;
    assign writeData    = wdata_q;
    assign SizeLoad     = size_q;
    assign MemWrite     = mw_q;
    assign grant_d      = grant_d_q;
    assign timeout_err  = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, scoreboard-driven memory_com model,
// and hand-written sequences for pairs, back-to-back loads, watchdog and reset.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int TO = 10;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0, reset;
    logic        if_req, d_read, d_write, mem_done, if_done, d_done;
    logic [31:0] if_addr, d_addr, d_wdata, readData, if_rdata, d_rdata, address, writeData;
    logic [2:0]  d_sizeload, SizeLoad;
    logic [1:0]  d_memwrite, MemWrite;
    logic        write_enable, read_enable, grant_d, timeout_err;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO), .TW(8)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_sizeload(d_sizeload), .d_memwrite(d_memwrite), .d_rdata(d_rdata), .d_done(d_done),
        .write_enable(write_enable), .read_enable(read_enable), .address(address),
        .writeData(writeData), .SizeLoad(SizeLoad), .MemWrite(MemWrite),
        .mem_done(mem_done), .readData(readData), .grant_d(grant_d), .timeout_err(timeout_err)
    );

    typedef struct {
        logic        is_d, wr, rd;
        logic [31:0] addr, wdata;
        logic [2:0]  size;
        logic [1:0]  mw;
        logic [31:0] resp;
        int          lat;
    } vec_t;

    typedef struct {
        logic        we, re, gd;
        logic [31:0] addr, wdata;
        logic [2:0]  size;
        logic [1:0]  mw;
        logic [31:0] resp;
    } dn_t;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
    } up_t;

    dn_t dn_q[$];
    up_t up_q[$];
    int  checks = 0, passes = 0;
    int  txn_cnt = 0, rcnt = 0, mem_lat = 2, spur_req = 0, spur_ack = 0;
    bit  mem_auto = 1'b1;
    dn_t cur;
    logic [31:0] last_if = '0, last_d = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // memory_com model: checks each new transaction against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            mem_done = 1'b0;
            rcnt     = 0;
        end else if (mem_done) begin
            mem_done = 1'b0;
            rcnt     = 0;
        end else if (read_enable | write_enable) begin
            if (rcnt == 0) begin
                txn_cnt++;
                chk("txn_expected", 32'(dn_q.size() != 0), 32'd1);
                if (dn_q.size() != 0) begin
                    cur = dn_q.pop_front();
                    chk("we", 32'(write_enable), 32'(cur.we));
                    chk("re", 32'(read_enable), 32'(cur.re));
                    chk("size", 32'(SizeLoad), 32'(cur.size));
                    chk("memwrite", 32'(MemWrite), 32'(cur.mw));
                    chk("grant_d", 32'(grant_d), 32'(cur.gd));
                end
            end
            chk("hold_addr", address, cur.addr);
            chk("hold_wdata", writeData, cur.wdata);
            rcnt++;
            if (mem_auto && rcnt >= mem_lat) begin
                mem_done = 1'b1;
                readData = cur.resp;
            end
        end else if (spur_req != spur_ack) begin
            mem_done = 1'b1;
            readData = 32'hBAD0_BAD0;
            spur_ack++;
        end else begin
            rcnt = 0;
        end
    end

    // Completion monitor: each done pulse must match the scoreboard head
    always @(negedge clk) begin
        if (!reset && (if_done | d_done)) begin
            up_t u;
            chk("done_expected", 32'(up_q.size() != 0), 32'd1);
            chk("done_one_hot", 32'(if_done & d_done), 32'd0);
            chk("en_low_at_done", 32'(read_enable | write_enable), 32'd0);
            if (up_q.size() != 0) begin
                u = up_q.pop_front();
                chk("done_port", 32'(d_done), 32'(u.is_d));
                chk(u.is_d ? "d_rdata" : "if_rdata", u.is_d ? d_rdata : if_rdata, u.rdata);
            end
        end
    end

    task automatic expect_txn(input vec_t v);
        dn_t e;
        up_t u;
        e.gd = v.is_d;
        e.resp = v.resp;
        if (v.is_d) begin
            e.we = v.wr; e.re = !v.wr && v.rd; e.addr = v.addr; e.wdata = v.wdata;
            e.size = v.size; e.mw = v.mw;
        end else begin
            e.we = 1'b0; e.re = 1'b1; e.addr = v.addr; e.wdata = '0;
            e.size = SIZE_WORD; e.mw = MEMWRITE_NONE;
        end
        u.is_d = v.is_d;
        if (e.re) begin
            if (v.is_d) last_d = v.resp; else last_if = v.resp;
        end
        u.rdata = v.is_d ? last_d : last_if;
        dn_q.push_back(e);
        up_q.push_back(u);
    endtask

    task automatic drive(input vec_t v);
        if (v.is_d) begin
            d_write = v.wr; d_read = v.rd; d_addr = v.addr; d_wdata = v.wdata;
            d_sizeload = v.size; d_memwrite = v.mw;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
    endtask

    task automatic wait_done(output logic d_side);
        int n = 0;
        do begin step(); n++; end while (!(if_done | d_done) && n < 40);
        chk("done_seen", 32'(if_done | d_done), 32'd1);
        d_side = d_done;
    endtask

    task automatic drop_all();
        if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic do_vec(input vec_t v);
        logic ds;
        int   n0;
        mem_lat = v.lat;
        expect_txn(v);
        n0 = txn_cnt;
        drive(v);
        step();
        chk("en_cycle1", 32'(read_enable | write_enable), 32'd1);
        wait_done(ds);
        drop_all();
        step();
        chk("done_pulse", 32'(if_done | d_done), 32'd0);
        step();
        chk("single_txn", txn_cnt - n0, 32'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
        chk({tag, "_address"}, address, 32'd0);
        chk({tag, "_wdata"}, writeData, 32'd0);
        chk({tag, "_ctl"}, 32'({if_done, d_done, write_enable, read_enable, SizeLoad,
                                MemWrite, grant_d, timeout_err}), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drop_all();
        step();
        check_zero("rst");
        reset = 1'b0;
        dn_q.delete(); up_q.delete();
        last_if = '0; last_d = '0;
    endtask

    task automatic run_pair(input bit d_first, input logic [31:0] base);
        vec_t vd, vi;
        logic ds;
        int   n0;
        vd = '{1'b1, 1'b0, 1'b1, base, 32'h0, 3'b010, 2'b00, base ^ 32'h1111_0000, 2};
        vi = '{1'b0, 1'b0, 1'b0, base + 32'h100, 32'h0, 3'b000, 2'b00, base ^ 32'h2222_0000, 2};
        if (d_first) begin expect_txn(vd); expect_txn(vi); end
        else         begin expect_txn(vi); expect_txn(vd); end
        mem_lat = 2;
        n0 = txn_cnt;
        drive(vd); drive(vi);
        repeat (2) begin
            wait_done(ds);
            if (ds) d_read = 1'b0; else if_req = 1'b0;
        end
        step(); step();
        chk("pair_txns", txn_cnt - n0, 32'd2);
    endtask

    vec_t tbl[6];

    initial begin
        logic ds;
        int   n0;
        tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,           3'b000, 2'b00, 32'hDEAD_BEEF, 3};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h1234_5678,   3'b000, 2'b11, 32'hBAD0_BAD0, 2};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h0,           3'b001, 2'b00, 32'h0000_00A5, 1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D,   3'b100, 2'b01, 32'h5555_AAAA, 4};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,           3'b000, 2'b00, 32'h0000_0000, 5};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_3000, 32'hFFFF_FFFF,   3'b000, 2'b10, 32'h7777_7777, 1};

        reset = 1'b1; mem_done = 1'b0; readData = '0;
        if_req = 1'b0; if_addr = '0; d_read = 1'b0; d_write = 1'b0;
        d_addr = '0; d_wdata = '0; d_sizeload = '0; d_memwrite = '0;
        step();
        do_reset();

        foreach (tbl[i]) do_vec(tbl[i]);
        chk("no_timeout", 32'(timeout_err), 32'd0);

        // Spurious mem_done in IDLE must not start or complete anything
        n0 = txn_cnt;
        spur_req++;
        repeat (3) step();
        chk("spur_no_txn", txn_cnt - n0, 32'd0);
        chk("spur_idle_en", 32'(read_enable | write_enable), 32'd0);

        // Simultaneous requests after reset, then a single D grant, then another pair
        do_reset();
        run_pair(1'b1, 32'h0000_0500);
        do_vec('{1'b1, 1'b0, 1'b1, 32'h0000_0900, 32'h0, 3'b010, 2'b00, 32'h0BAD_CAFE, 2});
        run_pair(!RR, 32'h0000_0A00);

        // Back-to-back loads with d_read held continuously
        expect_txn('{1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'h0, 3'b010, 2'b00, 32'hAAAA_0001, 2});
        expect_txn('{1'b1, 1'b0, 1'b1, 32'h0000_1004, 32'h0, 3'b010, 2'b00, 32'hAAAA_0002, 2});
        mem_lat = 2;
        n0 = txn_cnt;
        d_read = 1'b1; d_addr = 32'h0000_1000; d_sizeload = 3'b010; d_memwrite = 2'b00;
        wait_done(ds);
        d_addr = 32'h0000_1004;
        step();
        chk("b2b_gap_en", 32'(read_enable | write_enable), 32'd0);
        step();
        chk("b2b_regrant", 32'(read_enable), 32'd1);
        wait_done(ds);
        drop_all();
        step(); step();
        chk("b2b_txns", txn_cnt - n0, 32'd2);

        // Watchdog with mem_done withheld; requester fields wiggle and must be ignored
        mem_auto = 1'b0;
        expect_txn('{1'b0, 1'b0, 1'b0, 32'h0000_0700, 32'h0, 3'b000, 2'b00, 32'h3333_3333, 1});
        if_req = 1'b1; if_addr = 32'h0000_0700;
        step();
        chk("wd_en", 32'(read_enable), 32'd1);
        if_addr = 32'hFFFF_0000; d_write = 1'b1; d_addr = 32'h1;
        repeat (9) step();
        chk("wd_before", 32'(timeout_err), 32'd0);
        step();
        chk("wd_set", 32'(timeout_err), 32'd1);
        mem_auto = 1'b1;
        wait_done(ds);
        chk("wd_port_if", 32'(ds), 32'd0);
        drop_all();
        step(); step();
        chk("wd_sticky", 32'(timeout_err), 32'd1);

        // Reset in the middle of a transaction
        do_reset();
        mem_auto = 1'b0;
        expect_txn('{1'b0, 1'b0, 1'b0, 32'h0000_0800, 32'h0, 3'b000, 2'b00, 32'h4444_4444, 1});
        if_req = 1'b1; if_addr = 32'h0000_0800;
        step(); step();
        chk("mid_busy_en", 32'(read_enable), 32'd1);
        do_reset();
        mem_auto = 1'b1;
        do_vec('{1'b0, 1'b0, 1'b0, 32'h0000_0804, 32'h0, 3'b000, 2'b00, 32'h5A5A_5A5A, 2});
        chk("post_rst_rdata", if_rdata, 32'h5A5A_5A5A);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
